// File: rtl/dma_status_update_mc_if.sv
// rtl/dma_status_update_mc_if.sv - status-update engine port bundle
interface dma_status_update_mc_if #(
  parameter int NUM_CH   = 2,
  parameter int STATUS_W = 25
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                dma_wr_done_valid_i;
  logic [CH_W-1:0]     dma_wr_done_ch_i;
  logic [STATUS_W-1:0] dma_wr_done_status_i;
  logic                dma_wr_done_ready_o;
  logic                dma_status_overflow_o;
  logic [31:0]         csr_control_i;
  logic [31:0]         csr_status_update_o;
  logic [3:0]          csr_status_update_be_o;
  logic                csr_status_update_rq_o;
  logic                csr_status_update_ack_i;
  logic                dma_desc_update_wr_o;
  logic [CH_W-1:0]     dma_desc_update_ch_o;
  logic [31:0]         dma_desc_update_data_o;
  logic [3:0]          dma_desc_update_be_o;
  logic                dma_desc_update_wait_rq;
  logic [NUM_CH-1:0]   dma_irq_clr_i;
  logic [NUM_CH-1:0]   dma_irq_pending_o;
  logic                dma_interupt_rq_o;

  modport slave (
    input  dma_wr_done_valid_i, dma_wr_done_ch_i, dma_wr_done_status_i,
    output dma_wr_done_ready_o, dma_status_overflow_o,
    input  csr_control_i,
    output csr_status_update_o, csr_status_update_be_o, csr_status_update_rq_o,
    input  csr_status_update_ack_i,
    output dma_desc_update_wr_o, dma_desc_update_ch_o, dma_desc_update_data_o,
    output dma_desc_update_be_o,
    input  dma_desc_update_wait_rq,
    input  dma_irq_clr_i,
    output dma_irq_pending_o, dma_interupt_rq_o
  );

  modport master (
    output dma_wr_done_valid_i, dma_wr_done_ch_i, dma_wr_done_status_i,
    input  dma_wr_done_ready_o, dma_status_overflow_o,
    output csr_control_i,
    input  csr_status_update_o, csr_status_update_be_o, csr_status_update_rq_o,
    output csr_status_update_ack_i,
    input  dma_desc_update_wr_o, dma_desc_update_ch_o, dma_desc_update_data_o,
    input  dma_desc_update_be_o,
    output dma_desc_update_wait_rq,
    output dma_irq_clr_i,
    input  dma_irq_pending_o, dma_interupt_rq_o
  );
endinterface

// File: rtl/dma_status_update_mc.sv
// rtl/dma_status_update_mc.sv - multi-channel DMA status FIFO, CSR/descriptor update and IRQ coalescing
module dma_status_update_mc #(
  parameter int NUM_CH     = 2,
  parameter int STATUS_W   = 25,
  parameter int FIFO_DEPTH = 32
) (
  input logic             clk,
  input logic             reset,
  dma_status_update_mc_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = CH_W + STATUS_W;
  localparam int CNT_W = STATUS_W - 3;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] RD_FIFO     = 3'd1;
  localparam logic [2:0] LD_REG      = 3'd2;
  localparam logic [2:0] UPDATE_CSR  = 3'd3;
  localparam logic [2:0] UPDATE_DESC = 3'd4;
  localparam logic [2:0] IRQ         = 3'd5;

  logic [2:0]          state, state_nxt;
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         fill;
  logic [EW-1:0]       fifo_q;
  logic                full, empty, wr_en, rd_en;
  logic [CH_W-1:0]     ch_r;
  logic [STATUS_W-1:0] status_r;
  logic                loaded_r;
  logic                overflow_r;
  logic [NUM_CH-1:0]   pending_r, set_vec;
  logic [7:0]          cnt_r [NUM_CH];
  logic [CH_W-1:0]     ch_idx;
  logic                ch_ok, eligible, fire;
  logic [7:0]          thr_eff, cnt_cur;
  logic [31:0]         csr_w, desc_w;
  logic                ctrl_unused;

  assign full  = (fill == (AW+1)'(FIFO_DEPTH));
  assign empty = (fill == '0);
  assign wr_en = bus.dma_wr_done_valid_i & ~full;
  assign rd_en = (state == RD_FIFO) & ~empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {bus.dma_wr_done_ch_i, bus.dma_wr_done_status_i};
  end

  // Non-show-ahead read: fifo_q is valid the cycle after rdreq (LD_REG).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      fifo_q     <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        fifo_q <= mem[rd_ptr];
      end
      case ({wr_en, rd_en})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (bus.dma_wr_done_valid_i && full) overflow_r <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (!empty) state_nxt = RD_FIFO;
      RD_FIFO:     state_nxt = LD_REG;
      LD_REG:      state_nxt = UPDATE_CSR;
      UPDATE_CSR:  if (bus.csr_status_update_ack_i)
                     state_nxt = status_r[STATUS_W-1] ? UPDATE_DESC : IRQ;
      UPDATE_DESC: if (!bus.dma_desc_update_wait_rq) state_nxt = IRQ;
      IRQ:         state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ch_r     <= '0;
      status_r <= '0;
      loaded_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == LD_REG) begin
        {ch_r, status_r} <= fifo_q;
        loaded_r         <= 1'b1;
      end
    end
  end

  // Channel numbers beyond NUM_CH never touch the per-channel IRQ state.
  assign ch_ok    = (int'(ch_r) < NUM_CH);
  assign ch_idx   = ch_ok ? ch_r : '0;
  assign cnt_cur  = cnt_r[ch_idx];
  assign thr_eff  = (bus.csr_control_i[23:16] == 8'd0) ? 8'd1 : bus.csr_control_i[23:16];
  assign eligible = (state == IRQ) & status_r[STATUS_W-2] & bus.csr_control_i[31]
                    & bus.csr_control_i[ch_idx] & ch_ok;
  assign fire     = eligible & (status_r[STATUS_W-3]
                    | (({1'b0, cnt_cur} + 9'd1) >= {1'b0, thr_eff}));

  always_comb begin
    set_vec = '0;
    for (int i = 0; i < NUM_CH; i++) set_vec[i] = fire & (ch_idx == CH_W'(i));
  end

  // Set wins over a same-cycle clear because set_vec is ORed in last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_r[i] <= '0;
    end else begin
      pending_r <= (pending_r & ~bus.dma_irq_clr_i) | set_vec;
      for (int i = 0; i < NUM_CH; i++) begin
        if (eligible && (ch_idx == CH_W'(i))) cnt_r[i] <= fire ? 8'd0 : cnt_r[i] + 8'd1;
      end
    end
  end

  always_comb begin
    csr_w               = '0;
    csr_w[28 +: CH_W]   = ch_r;
    csr_w[27]           = status_r[STATUS_W-3];
    csr_w[CNT_W-1:0]    = status_r[CNT_W-1:0];
    desc_w              = '0;
    desc_w[31]          = loaded_r;
    desc_w[30]          = status_r[STATUS_W-3];
    desc_w[CNT_W-1:0]   = status_r[CNT_W-1:0];
  end

  assign bus.dma_wr_done_ready_o    = ~full & ~reset;
  assign bus.dma_status_overflow_o  = overflow_r;
  assign bus.csr_status_update_o    = csr_w;
  assign bus.csr_status_update_be_o = {4{loaded_r}};
  assign bus.csr_status_update_rq_o = (state == UPDATE_CSR);
  assign bus.dma_desc_update_wr_o   = (state == UPDATE_DESC);
  assign bus.dma_desc_update_ch_o   = ch_r;
  assign bus.dma_desc_update_data_o = desc_w;
  assign bus.dma_desc_update_be_o   = {4{loaded_r}};
  assign bus.dma_irq_pending_o      = pending_r;
  assign bus.dma_interupt_rq_o      = |pending_r;

  assign ctrl_unused = &{1'b0, bus.csr_control_i};
endmodule

// File: tb/tb_dma_status_update_mc.sv
// tb/tb_dma_status_update_mc.sv - scoreboard bench for dma_status_update_mc
module tb_dma_status_update_mc;
  localparam int NUM_CH     = 2;
  localparam int STATUS_W   = 25;
  localparam int FIFO_DEPTH = 32;
  localparam int CH_W       = 1;
  localparam int CNT_W      = STATUS_W - 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dma_status_update_mc_if #(.NUM_CH(NUM_CH), .STATUS_W(STATUS_W)) bus ();

  dma_status_update_mc #(.NUM_CH(NUM_CH), .STATUS_W(STATUS_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]       exp_csr [$];
  logic [31:0]       exp_desc [$];
  int                exp_dch [$];
  int                mcnt [NUM_CH];
  logic [NUM_CH-1:0] mpend;
  int                csr_hs, desc_hs;

  bit bp_rand    = 1'b0;
  bit ack_force  = 1'b1;
  bit wait_force = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected bus words and coalescing outcome per accepted entry.
  task automatic model_accept(input int ch, input logic [STATUS_W-1:0] st);
    bit wb, irq, err;
    int bytes, thr;
    wb    = st[STATUS_W-1];
    irq   = st[STATUS_W-2];
    err   = st[STATUS_W-3];
    bytes = int'(st) % (1 << CNT_W);
    exp_csr.push_back(32'(ch * 32'h1000_0000 + (err ? 32'h0800_0000 : 0) + bytes));
    if (wb) begin
      exp_desc.push_back(32'(32'h8000_0000 + (err ? 32'h4000_0000 : 0) + bytes));
      exp_dch.push_back(ch);
    end
    if (irq && bus.csr_control_i[31] && bus.csr_control_i[ch]) begin
      thr = int'(bus.csr_control_i[23:16]);
      if (thr == 0) thr = 1;
      if (err || (mcnt[ch] + 1 >= thr)) begin
        mpend[ch] = 1'b1;
        mcnt[ch]  = 0;
      end else begin
        mcnt[ch]++;
      end
    end
  endtask

  task automatic model_reset();
    exp_csr.delete();
    exp_desc.delete();
    exp_dch.delete();
    for (int i = 0; i < NUM_CH; i++) mcnt[i] = 0;
    mpend = '0;
  endtask

  task automatic write_entry(input int ch, input logic [STATUS_W-1:0] st, output bit acc);
    bus.dma_wr_done_valid_i  = 1'b1;
    bus.dma_wr_done_ch_i     = CH_W'(ch);
    bus.dma_wr_done_status_i = st;
    @(negedge clk);
    acc = bus.dma_wr_done_ready_o;
    @(posedge clk); #1;
    bus.dma_wr_done_valid_i = 1'b0;
    if (acc) model_accept(ch, st);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_csr.size() != 0 || exp_desc.size() != 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drain_in_time"}, 32'(k < 3000), 32'd1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_irq(input string name);
    check({name, "_pending"}, 32'(bus.dma_irq_pending_o), 32'(mpend));
    check({name, "_irq_rq"}, 32'(bus.dma_interupt_rq_o), 32'(|mpend));
  endtask

  task automatic clear_irq(input logic [NUM_CH-1:0] m);
    bus.dma_irq_clr_i = m;
    @(posedge clk); #1;
    bus.dma_irq_clr_i = '0;
    mpend = mpend & ~m;
  endtask

  task automatic one(input int ch, input logic [STATUS_W-1:0] st, input string name);
    bit acc;
    write_entry(ch, st, acc);
    check({name, "_accepted"}, 32'(acc), 32'd1);
    drain(name);
    check_irq(name);
  endtask

  // Responder for the CSR ack and AVMM waitrequest.
  initial begin
    bus.csr_status_update_ack_i = 1'b0;
    bus.dma_desc_update_wait_rq = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_rand) begin
        bus.csr_status_update_ack_i = ($urandom_range(0, 2) != 0);
        bus.dma_desc_update_wait_rq = ($urandom_range(0, 2) == 0);
      end else begin
        bus.csr_status_update_ack_i = ack_force;
        bus.dma_desc_update_wait_rq = wait_force;
      end
    end
  end

  // Monitor: every cycle a request is up, its payload must match the head of the queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.csr_status_update_rq_o) begin
        if (exp_csr.size() == 0) begin
          check("csr_unexpected_rq", 32'd1, 32'd0);
        end else begin
          check("csr_word", bus.csr_status_update_o, exp_csr[0]);
          check("csr_be", 32'(bus.csr_status_update_be_o), 32'hF);
          if (bus.csr_status_update_ack_i) begin
            void'(exp_csr.pop_front());
            csr_hs++;
          end
        end
      end
      if (bus.dma_desc_update_wr_o) begin
        if (exp_desc.size() == 0) begin
          check("desc_unexpected_wr", 32'd1, 32'd0);
        end else begin
          check("desc_data", bus.dma_desc_update_data_o, exp_desc[0]);
          check("desc_ch", 32'(bus.dma_desc_update_ch_o), 32'(exp_dch[0]));
          check("desc_be", 32'(bus.dma_desc_update_be_o), 32'hF);
          if (!bus.dma_desc_update_wait_rq) begin
            void'(exp_desc.pop_front());
            void'(exp_dch.pop_front());
            desc_hs++;
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [STATUS_W-1:0] WB  = STATUS_W'(1) << (STATUS_W-1);
  localparam logic [STATUS_W-1:0] IRQ = STATUS_W'(1) << (STATUS_W-2);
  localparam logic [STATUS_W-1:0] ERR = STATUS_W'(1) << (STATUS_W-3);

  initial begin
    bit acc;
    int n_acc, n_rej, c0, d0, n;
    logic [STATUS_W-1:0] st;

    bus.dma_wr_done_valid_i  = 1'b0;
    bus.dma_wr_done_ch_i     = '0;
    bus.dma_wr_done_status_i = '0;
    bus.csr_control_i        = '0;
    bus.dma_irq_clr_i        = '0;
    csr_hs  = 0;
    desc_hs = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", 32'(bus.dma_wr_done_ready_o), 32'd1);
    check("rst_overflow", 32'(bus.dma_status_overflow_o), 32'd0);
    check("rst_rq", 32'(bus.csr_status_update_rq_o), 32'd0);
    check("rst_wr", 32'(bus.dma_desc_update_wr_o), 32'd0);
    check("rst_csr_word", bus.csr_status_update_o, 32'd0);
    check("rst_desc_data", bus.dma_desc_update_data_o, 32'd0);
    check_irq("rst");

    // Single entry, immediate handshakes.
    bus.csr_control_i = 32'h8001_0003;
    one(1, WB | IRQ | STATUS_W'(32'h40), "single");
    clear_irq(2'b10);
    check_irq("single_clr");

    // Coalescing with threshold 4 on channel 0.
    bus.csr_control_i = 32'h8004_0001;
    for (int i = 0; i < 4; i++) one(0, IRQ | STATUS_W'(i + 1), $sformatf("coal%0d", i));
    clear_irq(2'b01);
    one(0, IRQ | ERR | STATUS_W'(7), "coal_err");
    clear_irq(2'b01);

    // Masked channel keeps its counter; unmasking later proves it.
    bus.csr_control_i = 32'h8002_0003;
    one(1, IRQ | STATUS_W'(5), "mask_pre");
    bus.csr_control_i = 32'h8002_0001;
    one(1, IRQ | STATUS_W'(6), "mask_a");
    one(1, IRQ | ERR | STATUS_W'(7), "mask_b");
    bus.csr_control_i = 32'h0002_0003;
    one(1, IRQ | STATUS_W'(8), "mask_global");
    bus.csr_control_i = 32'h8002_0003;
    one(1, IRQ | STATUS_W'(9), "mask_post");
    clear_irq(2'b11);

    // Backpressure: ack withheld, then waitrequest held.
    c0 = csr_hs; d0 = desc_hs;
    ack_force = 1'b0; wait_force = 1'b1;
    write_entry(0, WB | STATUS_W'(32'h123), acc);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rq_held", 32'(bus.csr_status_update_rq_o), 32'd1);
    end
    ack_force = 1'b1;
    n = 0;
    while (!bus.dma_desc_update_wr_o && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_wr_held", 32'(bus.dma_desc_update_wr_o), 32'd1);
      @(negedge clk);
    end
    wait_force = 1'b0;
    @(posedge clk); #1;
    drain("bp");
    check("bp_csr_transfers", 32'(csr_hs - c0), 32'd1);
    check("bp_desc_transfers", 32'(desc_hs - d0), 32'd1);

    // Fill the FIFO while the CSR side is stalled.
    ack_force = 1'b0;
    n_acc = 0; n_rej = 0;
    for (int i = 0; i < FIFO_DEPTH + 4; i++) begin
      st = STATUS_W'($urandom) & ~ERR;
      write_entry(int'($urandom_range(0, NUM_CH - 1)), st, acc);
      if (acc) n_acc++; else n_rej++;
    end
    check("full_accepted", 32'(n_acc), 32'(FIFO_DEPTH + 1));
    check("full_ready_low", 32'(bus.dma_wr_done_ready_o), 32'd0);
    check("full_overflow", 32'(bus.dma_status_overflow_o), 32'd1);
    ack_force = 1'b1;
    drain("full");
    check_irq("full");
    check("full_ready_back", 32'(bus.dma_wr_done_ready_o), 32'd1);
    clear_irq(2'b11);

    // Randomized rounds under random backpressure.
    bp_rand = 1'b1;
    for (int r = 0; r < 20; r++) begin
      bus.csr_control_i = {($urandom_range(0, 3) != 0), 7'd0, 8'($urandom_range(0, 5)),
                           14'd0, 2'($urandom_range(0, 3))};
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        st = STATUS_W'($urandom);
        if ($urandom_range(0, 3) != 0) st = st & ~ERR;
        write_entry(int'($urandom_range(0, NUM_CH - 1)), st, acc);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      drain($sformatf("rnd%0d", r));
      check_irq($sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) != 0) clear_irq(NUM_CH'($urandom_range(0, 3)));
    end
    bp_rand = 1'b0;
    ack_force = 1'b1; wait_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset while the descriptor write is stalled.
    bus.csr_control_i = 32'h8001_0003;
    write_entry(0, WB | IRQ | STATUS_W'(3), acc);
    n = 0;
    while (!bus.dma_desc_update_wr_o && n < 50) begin @(negedge clk); n++; end
    check("rstd_wr_reached", 32'(bus.dma_desc_update_wr_o), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rstd_wr_async", 32'(bus.dma_desc_update_wr_o), 32'd0);
    check("rstd_pending", 32'(bus.dma_irq_pending_o), 32'd0);
    model_reset();
    wait_force = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rstd_ready", 32'(bus.dma_wr_done_ready_o), 32'd1);
    check("rstd_overflow", 32'(bus.dma_status_overflow_o), 32'd0);
    check("rstd_idle_rq", 32'(bus.csr_status_update_rq_o), 32'd0);
    check_irq("rstd");
    @(posedge clk); #1;
    one(1, WB | STATUS_W'(32'h55), "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
